// File: rtl/neuron_pkg.sv
// Shared defaults, FSM state encoding and class-index width for the argmax block.
package neuron_pkg;

  localparam int DATA_W_DEF    = 26;
  localparam int N_CLASSES_DEF = 10;
  localparam int CLASS_IDX_W   = 4;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/neuron_relu.sv
// Combinational ReLU clamp: negative two's-complement inputs become zero.
module neuron_relu #(
  parameter int DATA_W = 26
) (
  input  logic signed [DATA_W-1:0] din,
  output logic signed [DATA_W-1:0] dout
);

  assign dout = din[DATA_W-1] ? '0 : din;

endmodule

// File: rtl/neuron_argmax.sv
// Collects one result per class, then scans serially for the largest signed value.
// Optional NEURON_ARGMAX_RELU_EN clamps each captured slice to be non-negative.
module neuron_argmax
  import neuron_pkg::*;
#(
  parameter int N_CLASSES = N_CLASSES_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic                          clk,
  input  logic                          GlobalReset,
  input  logic [N_CLASSES*DATA_W-1:0]   Nrn_out,
  input  logic [N_CLASSES-1:0]          Nrn_valid,
  output logic [CLASS_IDX_W-1:0]        Class_idx,
  output logic signed [DATA_W-1:0]      Max_val,
  output logic                          Class_valid,
  output logic                          Busy,
  output logic                          Overrun
);

  localparam logic [CLASS_IDX_W-1:0] LAST_IDX = CLASS_IDX_W'(N_CLASSES - 1);

  state_t                   state, state_nxt;
  logic [N_CLASSES-1:0]     mask;
  logic signed [DATA_W-1:0] slice [N_CLASSES];
  logic signed [DATA_W-1:0] entry [N_CLASSES];
  logic [CLASS_IDX_W-1:0]   scan_idx;
  logic signed [DATA_W-1:0] best_val, cand, nxt_val;
  logic [CLASS_IDX_W-1:0]   best_idx, nxt_idx;
  logic                     scan_last, take_new;

  for (genvar k = 0; k < N_CLASSES; k++) begin : g_slice
`ifdef NEURON_ARGMAX_RELU_EN
    neuron_relu #(.DATA_W(DATA_W)) u_relu (
      .din  (Nrn_out[k*DATA_W +: DATA_W]),
      .dout (slice[k])
    );
`else
    assign slice[k] = Nrn_out[k*DATA_W +: DATA_W];
`endif
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) state <= COLLECT;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (&mask)     state_nxt = COMPARE;
      COMPARE: if (scan_last) state_nxt = DONE;
      DONE:                   state_nxt = COLLECT;
      default:                state_nxt = COLLECT;
    endcase
  end

  // Capture stage: last write per class wins while collecting
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      mask <= '0;
      for (int k = 0; k < N_CLASSES; k++) entry[k] <= '0;
    end else if (state == COLLECT) begin
      for (int k = 0; k < N_CLASSES; k++) begin
        if (Nrn_valid[k]) begin
          entry[k] <= slice[k];
          mask[k]  <= 1'b1;
        end
      end
    end else if (state == DONE) begin
      mask <= '0;
    end
  end

  always_comb begin
    cand = '0;
    for (int k = 0; k < N_CLASSES; k++) begin
      if (scan_idx == CLASS_IDX_W'(k)) cand = entry[k];
    end
  end

  // Strict greater-than keeps the lower index on ties
  assign scan_last = (scan_idx == LAST_IDX);
  assign take_new  = (scan_idx == '0) || (cand > best_val);
  assign nxt_val   = take_new ? cand : best_val;
  assign nxt_idx   = take_new ? scan_idx : best_idx;

  // Compare stage: one entry per cycle, result latched on the last entry
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      scan_idx  <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      Class_idx <= '0;
      Max_val   <= '0;
      Overrun   <= 1'b0;
    end else begin
      if (state == COLLECT) begin
        scan_idx <= '0;
      end else if (state == COMPARE) begin
        scan_idx <= scan_idx + 1'b1;
        best_val <= nxt_val;
        best_idx <= nxt_idx;
        if (scan_last) begin
          Class_idx <= nxt_idx;
          Max_val   <= nxt_val;
        end
      end
      if ((state != COLLECT) && (|Nrn_valid)) Overrun <= 1'b1;
    end
  end

  assign Class_valid = (state == DONE);
  assign Busy        = (state != COLLECT);

endmodule

// File: tb/tb_neuron_argmax.sv
// Directed-vector bench for neuron_argmax: stimulus pushes expected results into
// a queue, a negedge monitor pops and compares whenever Class_valid pulses.
module tb_neuron_argmax;

  localparam int NC = 10;
  localparam int DW = 26;

  typedef struct {
    logic [3:0]           idx;
    logic signed [DW-1:0] val;
  } exp_t;

  logic                   clk;
  logic                   GlobalReset;
  logic [NC*DW-1:0]       Nrn_out;
  logic [NC-1:0]          Nrn_valid;
  logic [3:0]             Class_idx;
  logic signed [DW-1:0]   Max_val;
  logic                   Class_valid;
  logic                   Busy;
  logic                   Overrun;

  exp_t                   exp_q[$];
  logic signed [DW-1:0]   vals [NC];
  int                     n_cmp = 0;
  int                     n_err = 0;
  int                     lat, busy_cyc;

  neuron_argmax #(.N_CLASSES(NC), .DATA_W(DW)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .Nrn_out     (Nrn_out),
    .Nrn_valid   (Nrn_valid),
    .Class_idx   (Class_idx),
    .Max_val     (Max_val),
    .Class_valid (Class_valid),
    .Busy        (Busy),
    .Overrun     (Overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!GlobalReset && Class_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(Class_idx), -32'sd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("class_idx", 32'(Class_idx), 32'(e.idx));
        check("max_val", 32'(Max_val), 32'(e.val));
      end
    end
  end

  task automatic push_exp(input logic [3:0] idx, input logic signed [DW-1:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic send_all();
    for (int k = 0; k < NC; k++) Nrn_out[k*DW +: DW] = vals[k];
    Nrn_valid = '1;
    @(posedge clk); #1;
    Nrn_valid = '0;
  endtask

  task automatic send_stagger();
    for (int k = 0; k < NC; k++) begin
      Nrn_out[k*DW +: DW] = vals[k];
      Nrn_valid = NC'(1) << k;
      @(posedge clk); #1;
    end
    Nrn_valid = '0;
  endtask

  // Counts edges from the last capture to Class_valid, and cycles with Busy high
  task automatic wait_result(output int l, output int b);
    l = 0;
    b = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (Busy) b++;
      if (Class_valid && l == 0) l = c;
      if (l != 0 && !Busy) break;
    end
    if (l == 0) check("result_timeout", 0, 1);
  endtask

  initial begin
    GlobalReset = 1'b1;
    Nrn_out     = '0;
    Nrn_valid   = '0;
    #1;
    check("rst_class_idx", 32'(Class_idx), 0);
    check("rst_max_val", 32'(Max_val), 0);
    check("rst_class_valid", 32'(Class_valid), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_overrun", 32'(Overrun), 0);
    repeat (3) @(posedge clk);
    #1 GlobalReset = 1'b0;
    @(posedge clk); #1;

    // All valids together, values 3k
    for (int k = 0; k < NC; k++) vals[k] = DW'(3 * k);
    push_exp(4'd9, 26'sd27);
    send_all();
    wait_result(lat, busy_cyc);
    check("latency_all", lat, 11);
    check("single_pulse", 32'(Class_valid), 0);

    // Staggered, class 4 wins
    for (int k = 0; k < NC; k++) vals[k] = 26'sd5;
    vals[4] = 26'sd1000;
    push_exp(4'd4, 26'sd1000);
    send_stagger();
    wait_result(lat, busy_cyc);
    check("busy_cycles", busy_cyc, 11);
    check("hold_class_idx", 32'(Class_idx), 4);
    check("hold_max_val", 32'(Max_val), 1000);

    // Tie between 2 and 7 keeps the lower index
    for (int k = 0; k < NC; k++) vals[k] = -26'sd1;
    vals[2] = 26'sd500;
    vals[7] = 26'sd500;
    push_exp(4'd2, 26'sd500);
    send_all();
    wait_result(lat, busy_cyc);

    // All negative
    for (int k = 0; k < NC; k++) vals[k] = -DW'(3 + k);
`ifdef NEURON_ARGMAX_RELU_EN
    push_exp(4'd0, 26'sd0);
`else
    push_exp(4'd0, -26'sd3);
`endif
    send_all();
    wait_result(lat, busy_cyc);

    // Early class 0 value overwritten by the staggered frame (last value wins)
    Nrn_out[0 +: DW] = 26'sd2000;
    Nrn_valid = NC'(1);
    @(posedge clk); #1;
    Nrn_valid = '0;
    for (int k = 0; k < NC; k++) vals[k] = DW'(k);
    push_exp(4'd9, 26'sd9);
    send_stagger();
    wait_result(lat, busy_cyc);
    check("no_overrun_on_rewrite", 32'(Overrun), 0);

    // Full-scale signed extremes
    for (int k = 0; k < NC; k++) vals[k] = '0;
    vals[5] = -26'sd33554432;
    vals[6] = 26'sd33554431;
    push_exp(4'd6, 26'sd33554431);
    send_all();
    wait_result(lat, busy_cyc);

    // Valid during COMPARE is dropped and flags Overrun
    for (int k = 0; k < NC; k++) vals[k] = DW'(3 * k);
    push_exp(4'd9, 26'sd27);
    send_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    Nrn_out[0 +: DW] = 26'sd5000;
    Nrn_valid = NC'(1);
    @(posedge clk); #1;
    Nrn_valid = '0;
    wait_result(lat, busy_cyc);
    check("overrun_set", 32'(Overrun), 1);

    for (int k = 0; k < NC; k++) vals[k] = DW'(10 - k);
    push_exp(4'd0, 26'sd10);
    send_all();
    wait_result(lat, busy_cyc);
    check("overrun_sticky", 32'(Overrun), 1);

    // Reset three cycles into COMPARE: no result, everything cleared
    for (int k = 0; k < NC; k++) vals[k] = DW'(k);
    send_all();
    repeat (4) @(posedge clk);
    #1 GlobalReset = 1'b1;
    #1;
    check("mid_rst_class_idx", 32'(Class_idx), 0);
    check("mid_rst_max_val", 32'(Max_val), 0);
    check("mid_rst_class_valid", 32'(Class_valid), 0);
    check("mid_rst_busy", 32'(Busy), 0);
    check("mid_rst_overrun", 32'(Overrun), 0);
    @(posedge clk); #1;
    GlobalReset = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("post_rst_idle_busy", 32'(Busy), 0);

    for (int k = 0; k < NC; k++) vals[k] = 26'sd5;
    vals[4] = 26'sd1000;
    push_exp(4'd4, 26'sd1000);
    send_all();
    wait_result(lat, busy_cyc);
    check("post_rst_latency", lat, 11);

    repeat (3) @(posedge clk);
    #1;
    check("pending_results", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
